// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// access-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Width codes with no meaning, plus unsigned widths used with a store.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic ill;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = we;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_steer.sv
// Little-endian lane arithmetic: extracts/extends load data and merges
// sub-word store data into a memory word.
module lsu_lane_steer
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = word[8*addr +: 8];
    assign half_s = word[16*addr[1] +: 16];

    // Load extraction with sign or zero extension.
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Read-modify-write merge of the store lane into the fetched word.
    always_comb begin
        merged_word = word;
        case (funct3)
            F3_B:    merged_word[8*addr +: 8] = wdata[7:0];
            F3_H:    merged_word[16*addr[1] +: 16] = wdata[15:0];
            F3_W:    merged_word = wdata;
            default: merged_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator FSM: accepts one request, runs at most one read and
// one write on the word-wide memory, and returns a one-cycle response.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    lsu_state_e                 state_r, state_s;
    logic                       we_r;
    logic [2:0]                 funct3_r;
    logic [ADDRESS_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]      wdata_r;
    logic [DATA_WIDTH-1:0]      word_r;
    logic [DATA_WIDTH-1:0]      rdata_r;
    logic                       err_r;
    logic                       req_err_s;
    logic                       accept_s;
    logic [31:0]                load_data_s;
    logic [31:0]                merged_word_s;

    assign req_err_s = is_misaligned(req_funct3, req_addr[1:0]) | is_illegal(req_we, req_funct3);
    assign accept_s  = (state_r == IDLE) && req_valid;

    lsu_lane_steer u_lane_steer (
        .word        (mem_rd),
        .addr        (addr_r[1:0]),
        .funct3      (funct3_r),
        .wdata       (wdata_r),
        .load_data   (load_data_s),
        .merged_word (merged_word_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; sub-word stores take the READ detour for RMW.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_err_s) begin
                        state_s = RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_s = WRITE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (we_r) begin
                    state_s = WRITE;
                end else begin
                    state_s = RESP;
                end
            end
            WRITE:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latch and word capture; word_r doubles as the write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= '0;
            wdata_r  <= '0;
            word_r   <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                err_r    <= req_err_s;
                rdata_r  <= '0;
                word_r   <= (req_we && !req_err_s) ? req_wdata : '0;
            end else if (state_r == READ) begin
                if (we_r) begin
                    word_r <= merged_word_s;
                end else begin
                    word_r  <= mem_rd;
                    rdata_r <= load_data_s;
                end
            end
        end
    end

    assign req_ready  = (state_r == IDLE) && rst_n;
    assign resp_valid = (state_r == RESP);
    assign resp_err   = (state_r == RESP) && err_r;
    assign resp_rdata = (state_r == RESP) ? rdata_r : '0;
    assign mem_a      = {addr_r[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_we     = (state_r == WRITE);
    assign mem_wd     = word_r;

endmodule
